// File: rtl/mult_div_unit_pkg.sv
// Shared CPU parameter header for the multiply/divide unit.
// Holds the MDOp encodings, the default multiply/divide latencies and the
// multiply/divide FSM state type.
package mult_div_unit_pkg;

  // E-stage multiply/divide operation encodings (4-bit MDOp field).
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  // Default Busy lengths for multiply and divide.
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// An operation is issued with Start plus MDOp in MULT..DIVU; the operands are
// latched and Busy stays high for MULT_CYCLES/DIV_CYCLES cycles, after which
// HI/LO load the result. MTHI/MTLO write In0 when idle; MFHI/MFLO read via Res.
//
// Ports:
//   clk    in   1   sole clock, rising edge
//   reset  in   1   synchronous, active-high
//   In0    in   32  rs operand
//   In1    in   32  rt operand
//   MDOp   in   4   operation code (see mult_div_unit_pkg::md_op_e)
//   Start  in   1   issue strobe for MULT/MULTU/DIV/DIVU
//   Busy   out  1   registered, high while an operation is in flight
//   HI     out  32  architectural HI register
//   LO     out  32  architectural LO register
//   Res    out  32  combinational MFHI/MFLO read data
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] In0,
  input  logic [31:0] In1,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Res
);

  localparam int unsigned CW = $clog2(DIV_CYCLES) + 1;

  md_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_op0;
  logic [31:0] r_op1;
  logic        r_signed;

  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div0;
  logic        w_is_mul;
  logic        w_is_div;

  assign w_is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
  assign w_is_div = (MDOp == MD_DIV)  || (MDOp == MD_DIVU);

  // Product from the latched operands, sign- or zero-extended to 64 bits.
  always_comb begin
    if (r_signed) begin
      w_prod = $signed({{32{r_op0[31]}}, r_op0}) * $signed({{32{r_op1[31]}}, r_op1});
    end else begin
      w_prod = {32'b0, r_op0} * {32'b0, r_op1};
    end
  end

  // Quotient/remainder. Divide-by-zero is never evaluated; the signed
  // overflow case (min / -1) is pinned explicitly rather than left to the
  // operator's wrap behaviour.
  always_comb begin
    w_quo  = '0;
    w_rem  = '0;
    w_div0 = (r_op1 == '0);
    if (!w_div0) begin
      if (r_signed) begin
        if ((r_op0 == 32'h8000_0000) && (r_op1 == '1)) begin
          w_quo = r_op0;
          w_rem = '0;
        end else begin
          w_quo = $signed(r_op0) / $signed(r_op1);
          w_rem = $signed(r_op0) % $signed(r_op1);
        end
      end else begin
        w_quo = r_op0 / r_op1;
        w_rem = r_op0 % r_op1;
      end
    end
  end

  // The counter is loaded with N on the Start edge and the result lands on
  // the edge where it reads 1, giving exactly N registered Busy cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      Busy     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      r_op0    <= '0;
      r_op1    <= '0;
      r_signed <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start && w_is_mul) begin
            r_op0    <= In0;
            r_op1    <= In1;
            r_signed <= (MDOp == MD_MULT);
            r_cnt    <= CW'(MULT_CYCLES);
            Busy     <= 1'b1;
            r_state  <= ST_MUL;
          end else if (Start && w_is_div) begin
            r_op0    <= In0;
            r_op1    <= In1;
            r_signed <= (MDOp == MD_DIV);
            r_cnt    <= CW'(DIV_CYCLES);
            Busy     <= 1'b1;
            r_state  <= ST_DIV;
          end else if (MDOp == MD_MTHI) begin
            HI <= In0;
          end else if (MDOp == MD_MTLO) begin
            LO <= In0;
          end
        end
        ST_MUL: begin
          if (r_cnt == CW'(1)) begin
            HI      <= w_prod[63:32];
            LO      <= w_prod[31:0];
            r_cnt   <= '0;
            Busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DIV: begin
          if (r_cnt == CW'(1)) begin
            if (!w_div0) begin
              HI <= w_rem;
              LO <= w_quo;
            end
            r_cnt   <= '0;
            Busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Res = '0;
    if (MDOp == MD_MFHI) begin
      Res = HI;
    end else if (MDOp == MD_MFLO) begin
      Res = LO;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table-driven operations with a
// scoreboard queue, plus hand-written sequences for MTHI/MTLO, ignored
// operations while busy, and reset during a divide.
module tb_mult_div_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk;
  logic        reset;
  logic [31:0] In0;
  logic [31:0] In1;
  logic [3:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Res;

  int unsigned checks;
  int unsigned errors;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .In0  (In0),
    .In1  (In1),
    .MDOp (MDOp),
    .Start(Start),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO),
    .Res  (Res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int unsigned op_cycles(input logic [3:0] op);
    return (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
  endfunction

  // Reference model; divide by zero keeps the previous HI/LO.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    longint      q;
    longint      r;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
        hi = up[63:32]; lo = up[31:0];
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      OP_DIV: if (b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        up = q; lo = up[31:0];
        up = r; hi = up[31:0];
      end
      OP_DIVU: if (b != 0) begin
        lo = a / b; hi = a % b;
      end
      default: ;
    endcase
  endtask

  // Issue one operation, push its expectation, then wait (bounded) for Busy
  // to fall and compare. disturb=1 drives MTLO and a second Start while busy.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit disturb);
    exp_t e;
    int unsigned n;
    @(posedge clk); #1;
    MDOp = op; In0 = a; In1 = b; Start = 1'b1;
    e.hi = ehi; e.lo = elo; e.cyc = op_cycles(op);
    sb.push_back(e);
    @(posedge clk); #1;
    Start = 1'b0; MDOp = OP_NONE; In0 = $urandom; In1 = $urandom;
    n = 0;
    while (Busy && n < 50) begin
      n++;
      if (disturb) begin
        if (n % 2 == 1) begin
          MDOp = OP_MTLO; In0 = 32'hDEAD_BEEF; Start = 1'b0;
        end else begin
          MDOp = OP_DIV; In0 = 32'd99; In1 = 32'd3; Start = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    Start = 1'b0; MDOp = OP_NONE;
    if (Busy) begin
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_busycyc"}, 32'(n), 32'(e.cyc));
      chk({name, "_hi"}, HI, e.hi);
      chk({name, "_lo"}, LO, e.lo);
      MDOp = OP_MFLO; #1;
      chk({name, "_mflo"}, Res, e.lo);
      MDOp = OP_MFHI; #1;
      chk({name, "_mfhi"}, Res, e.hi);
      MDOp = OP_NONE;
    end
  endtask

  initial begin
    vec_t tbl[11];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;

    tbl[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
    tbl[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{OP_DIVU,  32'd7,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5]  = '{OP_DIVU,  32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC};
    tbl[6]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[8]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[9]  = '{OP_DIV,   32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
    tbl[10] = '{OP_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};

    checks = 0; errors = 0;
    reset = 1'b1; In0 = '0; In1 = '0; MDOp = OP_NONE; Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_res", Res, 32'd0);
    reset = 1'b0;

    // MTHI with Start high while idle: writes HI, no operation starts.
    @(posedge clk); #1;
    MDOp = OP_MTHI; In0 = 32'h0000_1234; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("mthi_hi", HI, 32'h0000_1234);
    chk("mthi_busy", 32'(Busy), 32'd0);
    MDOp = OP_MTLO; In0 = 32'h0000_5678;
    @(posedge clk); #1;
    MDOp = OP_NONE;
    chk("mtlo_lo", LO, 32'h0000_5678);
    chk("mtlo_hi_kept", HI, 32'h0000_1234);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b0);
    end
    m_hi = tbl[10].hi; m_lo = tbl[10].lo;

    // MTLO and a second Start during a MULT are both ignored.
    m_hi = 32'd0; m_lo = 32'd12;
    run_op("mul_disturb", OP_MULT, 32'd3, 32'd4, m_hi, m_lo, 1'b1);

    // Reset in busy cycle 4 of a DIV aborts it with no late writeback.
    @(posedge clk); #1;
    MDOp = OP_DIV; In0 = 32'd100; In1 = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = OP_NONE;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_busy_before", 32'(Busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("abort_hi_late", HI, 32'd0);
    chk("abort_lo_late", LO, 32'd0);
    chk("abort_busy_late", 32'(Busy), 32'd0);
    m_hi = '0; m_lo = '0;

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = 4'(1 + $urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ((rop == OP_DIV || rop == OP_DIVU) ? 32'($urandom_range(1, 1000)) : $urandom);
      model(rop, ra, rb, m_hi, m_lo);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, m_hi, m_lo, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
